// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder built around a single 1-bit full-adder
// slice. Operands are consumed LSB-first, one bit per clock, with the slice
// carry held in a flip-flop between bits. The completed sum and final carry
// are registered and announced with a one-cycle done pulse.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] acc;
    logic             carry;
    logic [CW-1:0]    count;

    logic             s;
    logic             c;
    logic [WIDTH-1:0] shifted;

    // The full-adder slice for the current bit, plus the partial sum with
    // this bit shifted in at the top. The accumulator keeps only WIDTH-1
    // bits because the newest bit always arrives straight from the slice.
    always_comb begin
        s       = sa[0] ^ sb[0] ^ carry;
        c       = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));
        shifted = {s, acc};
    end

    // Control FSM and datapath: load on accept, one slice per clock in RUN,
    // publish the result on the last bit, then a single DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        carry <= cin;
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= shifted[WIDTH-1:1];
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    carry <= c;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        sum   <= shifted;
                        cout  <= c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of the 8-bit serial adder (table of
// hand-computed sums plus multi-cycle corner sequences) and an exhaustive
// sweep of a 4-bit instance.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       cin4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    int passed = 0;
    int total  = 0;
    int doneCount4 = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs[8];

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Count done pulses of the 4-bit instance, one sample per cycle
    always @(negedge clk) begin
        if (done4) doneCount4++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Request one 8-bit addition and wait (bounded) for done; lat is the
    // number of edges after the accepting edge, -1 if done never came.
    task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                                 output int lat, output bit runOk);
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        runOk = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (busy && done) runOk = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
            if (!busy) runOk = 1'b0;
        end
    endtask

    task automatic runVector(input string name, input logic [7:0] ta, input logic [7:0] tb,
                             input logic tc, input logic [7:0] esum, input logic ecout);
        int lat;
        bit runOk;
        applyStimulus(ta, tb, tc, lat, runOk);
        checkOutput({name, " latency"}, lat, 8);
        checkOutput({name, " busy during run"}, {31'd0, runOk}, 1);
        checkOutput({name, " sum"}, {24'd0, sum}, {24'd0, esum});
        checkOutput({name, " cout"}, {31'd0, cout}, {31'd0, ecout});
        @(posedge clk);
        #1 checkOutput({name, " done one cycle"}, {30'd0, busy, done}, 0);
    endtask

    task automatic runAdd4(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        int lat;
        logic [4:0] expected;
        expected = {1'b0, ta} + {1'b0, tb} + {4'd0, tc};
        @(negedge clk);
        a4 = ta; b4 = tb; cin4 = tc; start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (done4) begin
                lat = i;
                break;
            end
        end
        checkOutput("w4 latency", lat, 4);
        checkOutput("w4 result", {27'd0, cout4, sum4}, {27'd0, expected});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        bit sawDone;

        vecs[0] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[7] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

        // Reset, then idle with start low
        repeat (3) @(posedge clk);
        #1 checkOutput("in reset", {20'd0, busy, done, cout, sum}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 checkOutput("idle after reset", {20'd0, busy, done, cout, sum}, 0);
        end

        // Directed table of sums
        for (int i = 0; i < 8; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                      vecs[i].sum, vecs[i].cout);
        end

        // Start while busy: the second request at T3 and the start held
        // through DONE are ignored; the held start is taken at the first
        // edge seen in IDLE (T10).
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 a = 8'hFF; b = 8'hFF; start = 1'b1;
        lat = -1;
        for (int e = 3; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = e;
                break;
            end
        end
        checkOutput("busy-start latency", lat, 8);
        checkOutput("busy-start sum", {24'd0, sum}, 32'h30);
        checkOutput("busy-start cout", {31'd0, cout}, 0);
        @(posedge clk);
        #1 checkOutput("busy-start T9 idle", {30'd0, busy, done}, 0);
        @(posedge clk);
        #1 checkOutput("busy-start T10 accept", {31'd0, busy}, 1);
        start = 1'b0;
        lat = -1;
        for (int e = 11; e <= 30; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = e;
                break;
            end
        end
        checkOutput("second op latency", lat, 18);
        checkOutput("second op result", {23'd0, cout, sum}, 32'h1FE);
        @(posedge clk);
        #1;

        // Asynchronous reset between T4 and T5 aborts the operation
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1 checkOutput("mid-op reset outputs", {20'd0, busy, done, cout, sum}, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) sawDone = 1'b1;
        end
        checkOutput("no done after abort", {31'd0, sawDone}, 0);
        runVector("post-reset", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

        // Exhaustive 4-bit sweep
        doneCount4 = 0;
        for (int v = 0; v < 512; v++) begin
            runAdd4(v[7:4], v[3:0], v[8]);
        end
        checkOutput("w4 done count", doneCount4, 512);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
